// File: rtl/sprite_palette_lut.sv
// sprite_palette_lut: runtime-writable, banked colour palette with a 2-stage registered lookup pipeline.
// Ports:
//   Clk, Reset          clock, asynchronous active-high reset
//   pix_valid_i         lookup request; index_i selects entry, bank_i selects palette
//   fade_level_i        per-pixel brightness level (only used when PALETTE_FADE_EN is defined)
//   wr_valid_i/_ready_o palette write handshake; wr_bank_i/wr_addr_i/wr_data_i ({r,g,b}) select and data
//   pix_valid_o         result valid, 2 cycles after the request
//   red_o/green_o/blue_o colour result, zero when pix_valid_o is low
//   transparent_o       request index equalled KEY_INDEX
// Optional feature macro: PALETTE_FADE_EN scales each channel by (fade_level_i + 1) / 2**COLOR_W.
module sprite_palette_lut #(
    parameter int INDEX_W = 4,
    parameter int COLOR_W = 4,
    parameter int NUM_BANKS = 2,
    parameter int KEY_INDEX = 0,
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   pix_valid_i,
    input  logic [INDEX_W-1:0]     index_i,
    input  logic [BANK_W-1:0]      bank_i,
    input  logic [COLOR_W-1:0]     fade_level_i,
    input  logic                   wr_valid_i,
    output logic                   wr_ready_o,
    input  logic [BANK_W-1:0]      wr_bank_i,
    input  logic [INDEX_W-1:0]     wr_addr_i,
    input  logic [3*COLOR_W-1:0]   wr_data_i,
    output logic                   pix_valid_o,
    output logic [COLOR_W-1:0]     red_o,
    output logic [COLOR_W-1:0]     green_o,
    output logic [COLOR_W-1:0]     blue_o,
    output logic                   transparent_o
);
    localparam int DEPTH = 2 ** INDEX_W;
    localparam int ENT_W = 3 * COLOR_W;
    // One extra bit so a non-power-of-two bank count can be range checked
    localparam logic [BANK_W:0] BANKS = (BANK_W + 1)'(NUM_BANKS);
    localparam logic [INDEX_W-1:0] KEY = INDEX_W'(KEY_INDEX);

    logic [ENT_W-1:0]   mem_q [NUM_BANKS][DEPTH];
    logic [ENT_W-1:0]   mem_d [NUM_BANKS][DEPTH];
    logic               s1_valid_q, s1_valid_d;
    logic               s1_trans_q, s1_trans_d;
    logic [ENT_W-1:0]   s1_entry_q, s1_entry_d;
    logic [ENT_W-1:0]   faded;
    logic               valid_q, valid_d;
    logic               trans_q, trans_d;
    logic [ENT_W-1:0]   rgb_q, rgb_d;

    // Writes never stall; the port only refuses while held in reset
    assign wr_ready_o = ~Reset;

    // Stage 1 reads the old entry, so a same-cycle write to it is seen by the next lookup
    always_comb begin
        mem_d = mem_q;
        if (wr_valid_i && wr_ready_o && ({1'b0, wr_bank_i} < BANKS))
            mem_d[wr_bank_i][wr_addr_i] = wr_data_i;
        s1_valid_d = pix_valid_i;
        s1_trans_d = (index_i == KEY);
        s1_entry_d = ({1'b0, bank_i} < BANKS) ? mem_q[bank_i][index_i] : '0;
    end

`ifdef PALETTE_FADE_EN
    logic [COLOR_W-1:0] s1_fade_q;

    // Full-width product keeps (c * (level + 1)) exact before the shift
    always_comb begin
        logic [2*COLOR_W:0] prod;
        prod = '0;
        faded = '0;
        for (int c = 0; c < 3; c++) begin
            prod = (2*COLOR_W+1)'(s1_entry_q[c*COLOR_W +: COLOR_W]) * ((2*COLOR_W+1)'(s1_fade_q) + (2*COLOR_W+1)'(1));
            faded[c*COLOR_W +: COLOR_W] = prod[COLOR_W +: COLOR_W];
        end
    end

    always_ff @(posedge Clk or posedge Reset)
        if (Reset) s1_fade_q <= '0;
        else s1_fade_q <= fade_level_i;
`else
    logic unused_fade;
    assign unused_fade = ^fade_level_i;
    assign faded = s1_entry_q;
`endif

    always_comb begin
        valid_d = s1_valid_q;
        trans_d = s1_valid_q & s1_trans_q;
        rgb_d = s1_valid_q ? faded : '0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int b = 0; b < NUM_BANKS; b++)
                for (int i = 0; i < DEPTH; i++)
                    mem_q[b][i] <= '0;
            s1_valid_q <= 1'b0;
            s1_trans_q <= 1'b0;
            s1_entry_q <= '0;
            valid_q <= 1'b0;
            trans_q <= 1'b0;
            rgb_q <= '0;
        end else begin
            mem_q <= mem_d;
            s1_valid_q <= s1_valid_d;
            s1_trans_q <= s1_trans_d;
            s1_entry_q <= s1_entry_d;
            valid_q <= valid_d;
            trans_q <= trans_d;
            rgb_q <= rgb_d;
        end
    end

    assign pix_valid_o = valid_q;
    assign transparent_o = trans_q;
    assign red_o = rgb_q[ENT_W-1 -: COLOR_W];
    assign green_o = rgb_q[COLOR_W +: COLOR_W];
    assign blue_o = rgb_q[COLOR_W-1:0];
endmodule
